// File: rtl/uart_pkg.sv
// Shared UART definitions.
//   state_t           : transmit FSM state encoding, also exported on the debug port
//   DEFAULT_BAUD_DIV  : clocks per bit for a 100 MHz clock at 115200 baud
//   parity_bit()      : parity over a data word, even or odd sense
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam int DEFAULT_BAUD_DIV = 868;

  // Even sense returns the XOR of all bits; odd sense returns its complement.
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Divide-by-BAUD_DIV bit-period counter, shared by the transmit and receive sides.
//   clk      in  system clock
//   reset    in  synchronous active-high reset, count returns to 0
//   clear    in  restart the bit period; count is 0 in the following cycle
//   tick     out high in the last clock of each bit period (count == BAUD_DIV-1)
//   pre_tick out high one clock before tick (count == BAUD_DIV-2), lets users
//                register outputs that must line up with the last clock of a bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (r_count == CW'(BAUD_DIV - 1)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick     = (r_count == CW'(BAUD_DIV - 1));
  assign pre_tick = (r_count == CW'(BAUD_DIV - 2));

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: on an accepted load, sends one frame of
// start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
//   clk       in  system clock
//   reset     in  synchronous active-high reset; abandons any frame in flight
//   load      in  one-cycle start strobe, accepted only while tx_rdy=1
//   data_in   in  word to send, sampled only in the cycle load is accepted
//   tx        out registered serial line, idles high
//   tx_rdy    out 1 while IDLE, decoded from the state register
//   done      out registered one-cycle pulse in the last clock of the last stop bit
//   state_dbg out current FSM state (uart_pkg::state_t encoding)
//
// Handshake: load is a strobe qualified by tx_rdy. A load seen while tx_rdy=1
// is consumed on that edge; a load while tx_rdy=0 is dropped without effect.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 tx_rdy,
  output logic                 done,
  output logic [2:0]           state_dbg
);

  localparam int BW = $clog2(DATA_BITS);

  state_t               r_state;
  logic [DATA_BITS-1:0] r_shift;
  logic [BW-1:0]        r_bit_cnt;
  logic                 r_stop_cnt;
  logic                 r_parity;
  logic                 r_tx;
  logic                 r_done;

  state_t               w_state_n;
  logic [DATA_BITS-1:0] w_shift_n;
  logic [BW-1:0]        w_bit_cnt_n;
  logic                 w_stop_cnt_n;
  logic                 w_parity_n;
  logic                 w_tx_n;
  logic                 w_done_n;
  logic                 w_clear;
  logic                 w_tick;
  logic                 w_pre_tick;
  logic [7:0]           w_data_ext;

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .tick     (w_tick),
    .pre_tick (w_pre_tick)
  );

  assign w_data_ext = 8'(data_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_shift    <= w_shift_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_stop_cnt <= w_stop_cnt_n;
      r_parity   <= w_parity_n;
      r_tx       <= w_tx_n;
      r_done     <= w_done_n;
    end
  end

  // tx is registered, so each branch computes the line level for the state
  // being entered. The shift register holds the bits not yet placed on the line.
  always_comb begin
    w_state_n    = r_state;
    w_shift_n    = r_shift;
    w_bit_cnt_n  = r_bit_cnt;
    w_stop_cnt_n = r_stop_cnt;
    w_parity_n   = r_parity;
    w_tx_n       = r_tx;
    w_done_n     = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_n = 1'b1;
        if (load) begin
          w_state_n    = ST_START;
          w_shift_n    = data_in;
          w_parity_n   = parity_bit(w_data_ext, PARITY_ODD != 0);
          w_bit_cnt_n  = '0;
          w_stop_cnt_n = 1'b0;
          w_clear      = 1'b1;
          w_tx_n       = 1'b0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_n   = ST_DATA;
          w_bit_cnt_n = '0;
          w_tx_n      = r_shift[0];
          w_shift_n   = r_shift >> 1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            if (PARITY_EN != 0) begin
              w_state_n = ST_PARITY;
              w_tx_n    = r_parity;
            end else begin
              w_state_n    = ST_STOP;
              w_stop_cnt_n = 1'b0;
              w_tx_n       = 1'b1;
            end
          end else begin
            w_bit_cnt_n = r_bit_cnt + BW'(1);
            w_tx_n      = r_shift[0];
            w_shift_n   = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_tick) begin
          w_state_n    = ST_STOP;
          w_stop_cnt_n = 1'b0;
          w_tx_n       = 1'b1;
        end
      end
      ST_STOP: begin
        w_tx_n = 1'b1;
        // Raise done one clock early so the registered pulse lands on the
        // final clock of the last stop bit.
        if (w_pre_tick && (r_stop_cnt == 1'(STOP_BITS - 1))) begin
          w_done_n = 1'b1;
        end
        if (w_tick) begin
          if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
            w_state_n = ST_IDLE;
          end else begin
            w_stop_cnt_n = r_stop_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_tx_n    = 1'b1;
      end
    endcase
  end

  assign tx        = r_tx;
  assign done      = r_done;
  assign tx_rdy    = (r_state == ST_IDLE);
  assign state_dbg = r_state;

endmodule
